// File: rtl/conv2_stream_tx.sv
// ============================================================================
//  Module   : conv2_stream_tx
//  Function : conv2 input streamer. Forwards the weight ROM contents, buffers
//             one 3-channel feature map, then emits every KxK window beat by beat.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv2_stream_tx #(
    parameter int IMG_W = 14,
    parameter int IMG_H = 14,
    parameter int K     = 5,
    parameter int NUM_W = 225,
    parameter int DW    = 16,
    parameter int WW    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 w_rd_en,
    output logic [7:0]           w_addr,
    input  logic signed [WW-1:0] w_data,
    output logic signed [WW-1:0] o_filter,
    output logic                 o_weight_valid,
    input  logic                 i_weight_done,
    input  logic                 i_fm_valid,
    input  logic signed [DW-1:0] i_fm_ch0,
    input  logic signed [DW-1:0] i_fm_ch1,
    input  logic signed [DW-1:0] i_fm_ch2,
    output logic                 o_fm_ready,
    output logic signed [DW-1:0] o_data_ch0,
    output logic signed [DW-1:0] o_data_ch1,
    output logic signed [DW-1:0] o_data_ch2,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int AW    = $clog2(NPIX);
    localparam int KW    = (K > 1)     ? $clog2(K)     : 1;
    localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_TX    = 3'd1,
        S_W_WAIT  = 3'd2,
        S_FM_LOAD = 3'd3,
        S_WIN_TX  = 3'd4
    } state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [KW-1:0]   kx, ky;
    logic [XW-1:0]   ox;
    logic [YW-1:0]   oy;
    logic            issued_all;
    logic [3*DW-1:0] mem [NPIX];
    logic [AW-1:0]   rd_addr;
    logic [3*DW-1:0] rd_word;
    logic            fm_we;
    logic            last_pos;

    assign fm_we    = (state == S_FM_LOAD) && o_fm_ready && i_fm_valid;
    assign rd_addr  = AW'((int'(oy) + int'(ky)) * IMG_W + int'(ox) + int'(kx));
    assign rd_word  = mem[rd_addr];
    assign last_pos = (kx == KW'(K - 1)) && (ky == KW'(K - 1)) &&
                      (ox == XW'(OUT_W - 1)) && (oy == YW'(OUT_H - 1));
    assign o_busy   = (state != S_IDLE);
    // ROM data arrives one cycle after the strobe, so it is forwarded unregistered
    assign o_filter = o_weight_valid ? w_data : '0;

    always_ff @(posedge i_clk) begin
        if (fm_we) begin
            mem[wr_ptr] <= {i_fm_ch2, i_fm_ch1, i_fm_ch0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= S_IDLE;
            w_rd_en        <= 1'b0;
            w_addr         <= 8'd0;
            o_weight_valid <= 1'b0;
            o_fm_ready     <= 1'b0;
            wr_ptr         <= '0;
            kx             <= '0;
            ky             <= '0;
            ox             <= '0;
            oy             <= '0;
            issued_all     <= 1'b0;
            o_data_ch0     <= '0;
            o_data_ch1     <= '0;
            o_data_ch2     <= '0;
            o_valid        <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_weight_done) begin
                            state      <= S_FM_LOAD;
                            o_fm_ready <= 1'b1;
                            wr_ptr     <= '0;
                        end else begin
                            state   <= S_W_TX;
                            w_rd_en <= 1'b1;
                            w_addr  <= 8'd0;
                        end
                    end
                end
                S_W_TX: begin
                    o_weight_valid <= w_rd_en;
                    if (w_rd_en) begin
                        if (w_addr == 8'(NUM_W - 1)) begin
                            w_rd_en <= 1'b0;
                        end else begin
                            w_addr <= w_addr + 8'd1;
                        end
                    end else begin
                        // this cycle carries the final beat
                        state  <= S_W_WAIT;
                        w_addr <= 8'd0;
                    end
                end
                S_W_WAIT: begin
                    if (i_weight_done) begin
                        state      <= S_FM_LOAD;
                        o_fm_ready <= 1'b1;
                        wr_ptr     <= '0;
                    end
                end
                S_FM_LOAD: begin
                    if (fm_we) begin
                        if (wr_ptr == AW'(NPIX - 1)) begin
                            o_fm_ready <= 1'b0;
                            wr_ptr     <= '0;
                            state      <= S_WIN_TX;
                            kx         <= '0;
                            ky         <= '0;
                            ox         <= '0;
                            oy         <= '0;
                            issued_all <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                S_WIN_TX: begin
                    // output register refills whenever empty or being drained
                    if (!o_valid || i_ready) begin
                        if (issued_all) begin
                            o_valid    <= 1'b0;
                            o_done     <= 1'b1;
                            issued_all <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            o_data_ch0 <= rd_word[DW-1:0];
                            o_data_ch1 <= rd_word[2*DW-1:DW];
                            o_data_ch2 <= rd_word[3*DW-1:2*DW];
                            o_valid    <= 1'b1;
                            issued_all <= last_pos;
                            if (kx == KW'(K - 1)) begin
                                kx <= '0;
                                if (ky == KW'(K - 1)) begin
                                    ky <= '0;
                                    if (ox == XW'(OUT_W - 1)) begin
                                        ox <= '0;
                                        if (oy == YW'(OUT_H - 1)) begin
                                            oy <= '0;
                                        end else begin
                                            oy <= oy + 1'b1;
                                        end
                                    end else begin
                                        ox <= ox + 1'b1;
                                    end
                                end else begin
                                    ky <= ky + 1'b1;
                                end
                            end else begin
                                kx <= kx + 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
